// File: rtl/present_pkg.sv
// rtl/present_pkg.sv - shared constants and S-box lookup for the PRESENT key schedule
package present_pkg;

   // Legal master-key widths
   localparam int KW_80  = 80;
   localparam int KW_128 = 128;

   // Round-key width and round-counter width
   localparam int RK_W = 64;
   localparam int RC_W = 6;

   // PRESENT S-box packed so that entry x sits at bits [4*x+3:4*x]
   // (x = 0 -> C, x = 1 -> 5, ..., x = 15 -> 2)
   localparam logic [63:0] SBOX_TABLE = 64'h21748FE3DA09B65C;

   function automatic logic [3:0] sbox_lookup(input logic [3:0] x);
      return SBOX_TABLE[int'(x) * 4 +: 4];
   endfunction

endpackage

// File: rtl/present_sbox.sv
// rtl/present_sbox.sv - 4-bit PRESENT S-box
module present_sbox
   import present_pkg::*;
(
   input  logic [3:0] din,
   output logic [3:0] dout
);

   // Pure table lookup, no state
   assign dout = sbox_lookup(din);

endmodule

// File: rtl/key_sched.sv
// rtl/key_sched.sv - PRESENT key schedule for 80- or 128-bit master keys
module key_sched
   import present_pkg::*;
#(
   parameter int KW = 80,
   parameter int NR = 31
)(
   input  logic            ck,
   input  logic            rn,
   input  logic            sta,
   input  logic            act,
   input  logic            rld,
   input  logic [0:KW-1]   inp,
   output logic [0:KW-1]   key,
   output logic [0:RK_W-1] rk,
   output logic [RC_W-1:0] rc,
   output logic            last
);

   // Reject parameter values the schedule cannot support
   if (!(KW == KW_80 || KW == KW_128)) begin : g_bad_kw
      $error("key_sched: KW must be 80 or 128");
   end
   if (NR < 1 || NR > 31) begin : g_bad_nr
      $error("key_sched: NR must be in 1..31");
   end

   // Key register holds k[KW-1] at the left, matching inp/key bit 0 = MSB
   logic [KW-1:0]   key_q, key_d;
   logic [KW-1:0]   master_q, master_d;
   logic [RC_W-1:0] rc_q, rc_d;
   logic [KW-1:0]   rot;
   logic [KW-1:0]   step;
   logic            can_step;

   // Rotate left by 61 ahead of the S-box and counter injection
   always_comb begin
      rot = {key_q[KW-62:0], key_q[KW-1:KW-61]};
   end

   if (KW == KW_128) begin : g_kw128
      logic [3:0] sb_hi;
      logic [3:0] sb_lo;

      present_sbox u_sbox_hi (.din(rot[KW-1:KW-4]), .dout(sb_hi));
      present_sbox u_sbox_lo (.din(rot[KW-5:KW-8]), .dout(sb_lo));

      // Substitute the two top nibbles, then fold the round index into k[66:62]
      always_comb begin
         step        = {sb_hi, sb_lo, rot[KW-9:0]};
         step[66:62] = step[66:62] ^ rc_q[4:0];
      end
   end else begin : g_kw80
      logic [3:0] sb_hi;

      present_sbox u_sbox_hi (.din(rot[KW-1:KW-4]), .dout(sb_hi));

      // Substitute the top nibble, then fold the round index into k[19:15]
      always_comb begin
         step        = {sb_hi, rot[KW-5:0]};
         step[19:15] = step[19:15] ^ rc_q[4:0];
      end
   end

   // A round may only be taken while a loaded schedule has rounds left
   assign can_step = (rc_q != '0) && (rc_q <= RC_W'(NR));

   // Next-state selection: start beats reload beats advance beats hold
   always_comb begin
      key_d    = key_q;
      master_d = master_q;
      rc_d     = rc_q;
      if (sta) begin
         key_d    = inp;
         master_d = inp;
         rc_d     = RC_W'(1);
      end else if (rld) begin
         if (rc_q != '0) begin
            key_d = master_q;
            rc_d  = RC_W'(1);
         end
      end else if (act && can_step) begin
         key_d = step;
         rc_d  = rc_q + RC_W'(1);
      end
   end

   // State registers; reset wipes the stored master so a fresh start is needed
   always_ff @(posedge ck or negedge rn) begin
      if (!rn) begin
         key_q    <= '0;
         master_q <= '0;
         rc_q     <= '0;
      end else begin
         key_q    <= key_d;
         master_q <= master_d;
         rc_q     <= rc_d;
      end
   end

   assign key  = key_q;
   assign rk   = key_q[KW-1 -: RK_W];
   assign rc   = rc_q;
   assign last = (rc_q == RC_W'(NR + 1));

endmodule

// File: tb/tb_key_sched.sv
// tb/tb_key_sched.sv - randomized self-checking bench for key_sched (KW=80 and KW=128)
module tb_key_sched;

   localparam int NR = 31;

   logic         ck = 1'b0;
   logic         rn;
   logic         sta;
   logic         act;
   logic         rld;
   logic [0:79]  inp80;
   logic [0:127] inp128;

   logic [0:79]  key80;
   logic [0:63]  rk80;
   logic [5:0]   rc80;
   logic         last80;
   logic [0:127] key128;
   logic [0:63]  rk128;
   logic [5:0]   rc128;
   logic         last128;

   int n_vec  = 0;
   int n_miss = 0;

   // Reference state: the loaded master key and how many round keys deep we are
   logic [79:0]  m80_master;
   logic [127:0] m128_master;
   int           m_rc;

   int sb [16] = '{12, 5, 6, 11, 9, 0, 10, 13, 3, 14, 15, 8, 4, 7, 1, 2};

   key_sched #(.KW(80), .NR(NR)) u_dut80 (
      .ck(ck), .rn(rn), .sta(sta), .act(act), .rld(rld), .inp(inp80),
      .key(key80), .rk(rk80), .rc(rc80), .last(last80)
   );

   key_sched #(.KW(128), .NR(NR)) u_dut128 (
      .ck(ck), .rn(rn), .sta(sta), .act(act), .rld(rld), .inp(inp128),
      .key(key128), .rk(rk128), .rc(rc128), .last(last128)
   );

   always #5 ck = ~ck;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [79:0] f80(input logic [79:0] k, input int r);
      logic [79:0] t;
      t = (k << 61) | (k >> 19);
      t[79:76] = 4'(sb[t[79:76]]);
      t[19:15] = t[19:15] ^ 5'(r);
      return t;
   endfunction

   function automatic logic [127:0] f128(input logic [127:0] k, input int r);
      logic [127:0] t;
      t = (k << 61) | (k >> 67);
      t[127:124] = 4'(sb[t[127:124]]);
      t[123:120] = 4'(sb[t[123:120]]);
      t[66:62]   = t[66:62] ^ 5'(r);
      return t;
   endfunction

   // Round key number n is the master pushed through rounds 1..n-1
   function automatic logic [79:0] sched80(input logic [79:0] m, input int n);
      logic [79:0] k;
      k = m;
      for (int i = 1; i < n; i++) k = f80(k, i);
      return k;
   endfunction

   function automatic logic [127:0] sched128(input logic [127:0] m, input int n);
      logic [127:0] k;
      k = m;
      for (int i = 1; i < n; i++) k = f128(k, i);
      return k;
   endfunction

   task automatic model_edge();
      if (sta) begin
         m80_master  = inp80;
         m128_master = inp128;
         m_rc        = 1;
      end else if (rld) begin
         if (m_rc != 0) m_rc = 1;
      end else if (act && m_rc >= 1 && m_rc <= NR) begin
         m_rc++;
      end
   endtask

   task automatic model_reset();
      m80_master  = '0;
      m128_master = '0;
      m_rc        = 0;
   endtask

   task automatic check_all();
      logic [79:0]  e80;
      logic [127:0] e128;
      e80  = sched80(m80_master, m_rc);
      e128 = sched128(m128_master, m_rc);
      chk("key80",   128'(key80),   128'(e80));
      chk("rk80",    128'(rk80),    128'(e80[79:16]));
      chk("rc80",    128'(rc80),    128'(m_rc));
      chk("last80",  128'(last80),  128'(m_rc == NR + 1));
      chk("key128",  128'(key128),  e128);
      chk("rk128",   128'(rk128),   128'(e128[127:64]));
      chk("rc128",   128'(rc128),   128'(m_rc));
      chk("last128", 128'(last128), 128'(m_rc == NR + 1));
   endtask

   // Inputs are set at the falling edge; the model advances with the rising edge
   task automatic tick();
      model_edge();
      @(posedge ck);
      @(negedge ck);
      check_all();
   endtask

   // Pulse reset between clock edges and confirm it acts without a clock
   task automatic async_rst();
      #2 rn = 1'b0;
      model_reset();
      #1 check_all();
      #1 rn = 1'b1;
   endtask

   task automatic rand_inp();
      inp80  = {$urandom, $urandom, $urandom};
      inp128 = {$urandom, $urandom, $urandom, $urandom};
   endtask

   task automatic idle();
      sta = 1'b0;
      act = 1'b0;
      rld = 1'b0;
   endtask

   initial begin
      logic [79:0] k80_saved;
      rn = 1'b0;
      idle();
      inp80  = '0;
      inp128 = '0;
      model_reset();

      // Reset state
      @(negedge ck);
      check_all();
      rn = 1'b1;

      // act/rld before any start do nothing
      act = 1'b1;
      tick();
      act = 1'b0;
      rld = 1'b1;
      tick();
      idle();

      // Zero key: first round key and one round of each width
      sta = 1'b1;
      tick();
      sta = 1'b0;
      chk("zero_rc1", 128'(rc80), 128'(1));
      chk("zero_rk0", 128'(rk80), 128'(0));
      act = 1'b1;
      tick();
      act = 1'b0;
      chk("zero_k80",   128'(key80),  128'(80'hC0000000000000008000));
      chk("zero_rc2",   128'(rc80),   128'(2));
      chk("zero_k128",  128'(key128), 128'hCC000000000000004000000000000000);
      chk("zero_rk128", 128'(rk128),  128'(64'hCC00000000000000));

      // Full run with overshoot: counter saturates at NR+1 and key freezes
      rand_inp();
      sta = 1'b1;
      tick();
      sta = 1'b0;
      act = 1'b1;
      for (int i = 1; i <= 40; i++) begin
         tick();
         chk("last_run", 128'(last80), 128'(i >= NR));
      end
      act = 1'b0;
      chk("run_rc32", 128'(rc80), 128'(32));
      chk("run_k32",  128'(key80), 128'(sched80(m80_master, 32)));

      // Reload after 10 rounds, with act also high
      rand_inp();
      k80_saved = inp80;
      sta = 1'b1;
      tick();
      sta = 1'b0;
      act = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      rld = 1'b1;
      tick();
      idle();
      chk("rld_rc",  128'(rc80),  128'(1));
      chk("rld_key", 128'(key80), 128'(k80_saved));

      // Asynchronous reset mid-run, then act/rld are ignored
      act = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      async_rst();
      tick();
      act = 1'b0;
      rld = 1'b1;
      tick();
      idle();
      chk("post_rst_rc", 128'(rc80), 128'(0));

      // Start wins over reload and advance
      sta = 1'b1;
      tick();
      act = 1'b1;
      tick();
      rand_inp();
      k80_saved = inp80;
      sta = 1'b1;
      act = 1'b1;
      rld = 1'b1;
      tick();
      idle();
      chk("all3_key", 128'(key80), 128'(k80_saved));
      chk("all3_rc",  128'(rc80),  128'(1));

      // Random mix of controls and occasional reset
      for (int i = 0; i < 600; i++) begin
         sta = ($urandom_range(99) < 8);
         rld = ($urandom_range(99) < 8);
         act = ($urandom_range(99) < 75);
         if (sta) rand_inp();
         tick();
         if ($urandom_range(99) < 2) async_rst();
      end
      idle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/key_sched.md
KEY_SCHED -- requirements
Module: key_sched

Interface
REQ-001 Parameter KW, default 80: key width; the only legal values are 80 and 128.
REQ-002 Parameter NR, default 31: number of cipher rounds; legal range is 1..31.
REQ-003 ck  input  1: rising-edge clock; the block SHALL use this one clock only.
REQ-004 rn  input  1: reset, asynchronous, active-low.
REQ-005 sta  input  1: start; loads the master key.
REQ-006 act  input  1: advance the key schedule by one round.
REQ-007 rld  input  1: reload the stored master key without re-presenting inp.
REQ-008 inp  input  [0:KW-1]: master key; bit 0 is key MSB (k[KW-1]).
REQ-009 key  output  [0:KW-1]: current key register.
REQ-010 rk  output  [0:63]: current round key, equal to key[0:63].
REQ-011 rc  output  [5:0]: current round-key index; 0 means not loaded.
REQ-012 last  output  1: high when rc == NR+1, i.e. the final round key is presented.

Function
REQ-013 State SHALL be a key register, a KW-bit master-key shadow register and the rc counter; all outputs SHALL be registered.
REQ-014 Priority per ck edge SHALL be sta > rld > act > hold.
REQ-015 sta: key <= inp, master <= inp, rc <= 1, all in one cycle; the first round key appears on rk in the cycle after the sta edge.
REQ-016 rld with rc != 0: key <= master, rc <= 1.
REQ-017 rld with rc == 0: no effect.
REQ-018 act with 1 <= rc <= NR: key <= F(key, rc[4:0]), rc <= rc+1; latency is one cycle per round key.
REQ-019 act with rc == 0 or rc == NR+1: no effect; the counter SHALL NOT wrap, and key and rc SHALL hold.
REQ-020 F for KW=80: rotate left by 61 bits; S-box applied to nibble k[79:76]; k[19:15] ^= rc[4:0].
REQ-021 F for KW=128: rotate left by 61 bits; S-box applied to nibbles k[127:124] and k[123:120]; k[66:62] ^= rc[4:0].
REQ-022 S-box SHALL be the PRESENT S-box: C 5 6 B 9 0 A D 3 E F 8 4 7 1 2.
REQ-023 last SHALL be a combinational decode of the rc register (no extra cycle of latency).
REQ-024 sta asserted while the schedule is mid-run SHALL restart cleanly with the new inp, regardless of act or rld.

Reset
REQ-025 rn low SHALL immediately force key = 0, master = 0, rc = 0 and last = 0, independent of ck.
REQ-026 After rn deasserts, act and rld SHALL have no effect until a sta is seen.
REQ-027 Reset asserted mid-schedule SHALL discard the master key; a fresh sta is required.

Structure
REQ-028 Shared package present_pkg SHALL hold the S-box constant table, the legal KW values, the RK_W=64 width and the rc counter width of 6.
REQ-029 One sub-module present_sbox (4-bit in, 4-bit out) SHALL be instantiated once for KW=80 and twice for KW=128, inside a generate on KW.
REQ-030 Illegal KW or NR values SHALL be caught by an elaboration-time check.

Verification
REQ-031 KW=80: rn pulse, then sta with inp=0 -> rc=1, rk=0000000000000000; after one act -> key=C0000000000000008000, rc=2.
REQ-032 KW=128: sta with inp=0, then one act -> key=CC000000000000004000000000000000, rk=CC00000000000000.
REQ-033 KW=80, NR=31: sta, then 40 consecutive act -> rc stops at 32, last=1 from the 31st act onward; key is frozen after the 31st act and matches a software model of K32.
REQ-034 After 10 act, assert rld -> rc=1 and key equals the sta value; with rld and act high together, rld wins.
REQ-035 Assert rn low asynchronously mid-run (between edges) -> key=0 and rc=0 immediately; subsequent act or rld -> no change until sta.
REQ-036 sta, act and rld high together with a new inp -> key=new inp, rc=1.
